// File: rtl/sm_key_input_if.sv
// Board key/switch bundle: raw active-low pins in, debounced levels and event pulses out.
interface sm_key_input_if #(
  parameter int unsigned KEY_W = 4,
  parameter int unsigned SW_W  = 10
);
  logic [KEY_W-1:0] keyRaw;
  logic [SW_W-1:0]  swRaw;
  logic [KEY_W-1:0] keyDown;
  logic [KEY_W-1:0] keyPress;
  logic [KEY_W-1:0] keyRelease;
  logic [KEY_W-1:0] keyStep;
  logic [SW_W-1:0]  swSync;

  // Board side drives the pins and consumes the cleaned-up control.
  modport master (
    output keyRaw, swRaw,
    input  keyDown, keyPress, keyRelease, keyStep, swSync
  );

  // Input front-end.
  modport slave (
    input  keyRaw, swRaw,
    output keyDown, keyPress, keyRelease, keyStep, swSync
  );
endinterface

// File: rtl/sm_key_input.sv
// Board input front-end: synchronises and debounces push-buttons, emits press/release
// pulses and an auto-repeating step pulse per key, and synchronises slide switches.
module sm_key_input #(
  parameter int unsigned KEY_W         = 4,
  parameter int unsigned SW_W          = 10,
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned DEBOUNCE      = 500000,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic           clk,
  input  logic           rst_n,
  sm_key_input_if.slave  io_bus
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } step_state_t;

  logic [KEY_W-1:0] r_key_s1;
  logic [KEY_W-1:0] r_key_s2;
  logic [SW_W-1:0]  r_sw_s1;
  logic [SW_W-1:0]  r_sw_s2;
  logic [KEY_W-1:0] r_key_down;
  logic [KEY_W-1:0] r_key_press;
  logic [KEY_W-1:0] r_key_release;
  logic [KEY_W-1:0] r_key_step;
  logic [CNT_W-1:0] r_dcnt [KEY_W];
  logic [CNT_W-1:0] r_rcnt [KEY_W];
  step_state_t      r_state [KEY_W];

  logic [KEY_W-1:0] w_key_sync;
  logic [KEY_W-1:0] w_toggle;
  logic [KEY_W-1:0] w_rise;
  logic [KEY_W-1:0] w_fall;

  // Pins are active low; key flops reset to "released" so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= io_bus.keyRaw;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= io_bus.swRaw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  assign w_key_sync = ~r_key_s2;

  // A key's debounced level flips once its synced value has disagreed for DEBOUNCE cycles.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < KEY_W; i++) begin
      w_toggle[i] = (w_key_sync[i] != r_key_down[i]) && (r_dcnt[i] == DB_LAST);
    end
  end

  assign w_rise = w_toggle & ~r_key_down;
  assign w_fall = w_toggle &  r_key_down;

  // Debounce counters, debounced level and the press/release pulses that accompany its edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_down    <= '0;
      r_key_press   <= '0;
      r_key_release <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_key_down    <= r_key_down ^ w_toggle;
      r_key_press   <= w_rise;
      r_key_release <= w_fall;
      for (int i = 0; i < KEY_W; i++) begin
        if ((w_key_sync[i] == r_key_down[i]) || w_toggle[i]) begin
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Step FSM per key; a release edge takes priority over a repeat pulse due in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_step <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        r_state[i] <= ST_OFF;
        r_rcnt[i]  <= '0;
      end
    end else begin
      r_key_step <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        if (REPEAT_EN == 0) begin
          r_state[i]    <= ST_OFF;
          r_rcnt[i]     <= '0;
          r_key_step[i] <= w_rise[i];
        end else begin
          case (r_state[i])
            ST_OFF: begin
              r_rcnt[i] <= '0;
              if (w_rise[i]) begin
                r_key_step[i] <= 1'b1;
                r_state[i]    <= ST_DELAY;
              end
            end
            ST_DELAY: begin
              if (w_fall[i]) begin
                r_state[i] <= ST_OFF;
                r_rcnt[i]  <= '0;
              end else if (r_rcnt[i] == DELAY_LAST) begin
                r_key_step[i] <= 1'b1;
                r_state[i]    <= ST_RPT;
                r_rcnt[i]     <= '0;
              end else begin
                r_rcnt[i] <= r_rcnt[i] + CNT_W'(1);
              end
            end
            ST_RPT: begin
              if (w_fall[i]) begin
                r_state[i] <= ST_OFF;
                r_rcnt[i]  <= '0;
              end else if (r_rcnt[i] == RPT_LAST) begin
                r_key_step[i] <= 1'b1;
                r_rcnt[i]     <= '0;
              end else begin
                r_rcnt[i] <= r_rcnt[i] + CNT_W'(1);
              end
            end
            default: begin
              r_state[i] <= ST_OFF;
              r_rcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign io_bus.keyDown    = r_key_down;
  assign io_bus.keyPress   = r_key_press;
  assign io_bus.keyRelease = r_key_release;
  assign io_bus.keyStep    = r_key_step;
  assign io_bus.swSync     = r_sw_s2;

endmodule

// File: tb/tb_sm_key_input.sv
// Bench for sm_key_input: directed key/switch stimulus, expected pulse events queued
// per DUT and consumed by negedge monitors; REPEAT_EN=0 copy runs alongside.
module tb_sm_key_input;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned SW_W  = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [KEY_W-1:0] key_raw = '1;
  logic [SW_W-1:0]  sw_raw = '0;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  typedef struct {
    int         c;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] s;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm_key_input_if #(.KEY_W(KEY_W), .SW_W(SW_W)) bus1 ();
  sm_key_input_if #(.KEY_W(KEY_W), .SW_W(SW_W)) bus2 ();

  assign bus1.keyRaw = key_raw;
  assign bus1.swRaw  = sw_raw;
  assign bus2.keyRaw = key_raw;
  assign bus2.swRaw  = sw_raw;

  sm_key_input #(
    .KEY_W(KEY_W), .SW_W(SW_W), .CNT_W(8), .DEBOUNCE(4),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_rpt (
    .clk(clk), .rst_n(rst_n), .io_bus(bus1)
  );

  sm_key_input #(
    .KEY_W(KEY_W), .SW_W(SW_W), .CNT_W(8), .DEBOUNCE(4),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_norpt (
    .clk(clk), .rst_n(rst_n), .io_bus(bus2)
  );

  // Expected event; the no-repeat copy sees only press/release, with step mirroring press.
  task automatic exp_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
    ev_t e;
    e = '{c, p, r, s};
    q1.push_back(e);
    if ((p | r) != 4'd0) begin
      e = '{c, p, r, p};
      q2.push_back(e);
    end
  endtask

  function automatic void mon(input int id, input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
    ev_t e;
    int  sz;
    e  = '{0, 4'd0, 4'd0, 4'd0};
    sz = (id == 0) ? q1.size() : q2.size();
    if (sz != 0) begin
      if (id == 0) e = q1[0];
      else         e = q2[0];
    end
    if ((p | r | s) != 4'd0) begin
      n_checks++;
      if (sz == 0) begin
        n_fail++;
        $display("FAIL event dut%0d cyc=%0d got press=%b release=%b step=%b, required no event",
                 id, cyc, p, r, s);
      end else begin
        if (id == 0) void'(q1.pop_front());
        else         void'(q2.pop_front());
        if (e.c != cyc || e.p != p || e.r != r || e.s != s) begin
          n_fail++;
          $display("FAIL event dut%0d got cyc=%0d press=%b release=%b step=%b, required cyc=%0d press=%b release=%b step=%b",
                   id, cyc, p, r, s, e.c, e.p, e.r, e.s);
        end
      end
    end else if (sz != 0 && e.c <= cyc) begin
      n_checks++;
      n_fail++;
      if (id == 0) void'(q1.pop_front());
      else         void'(q2.pop_front());
      $display("FAIL missing dut%0d cyc=%0d got no event, required press=%b release=%b step=%b at cyc=%0d",
               id, cyc, e.p, e.r, e.s, e.c);
    end
  endfunction

  always @(negedge clk) begin
    mon(0, bus1.keyPress, bus1.keyRelease, bus1.keyStep);
    mon(1, bus2.keyPress, bus2.keyRelease, bus2.keyStep);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0h, required %0h", name, cyc, act, expv);
    end
  endtask

  // Drive point: just after the posedge that makes cyc == n.
  task automatic at_cyc(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  // Sample point: the negedge of cycle n.
  task automatic wait_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int p;
    int rr;

    rst_n   = 1'b0;
    key_raw = '1;
    sw_raw  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_keyDown",    32'(bus1.keyDown),    32'h0);
    chk("rst_keyPress",   32'(bus1.keyPress),   32'h0);
    chk("rst_keyRelease", 32'(bus1.keyRelease), 32'h0);
    chk("rst_keyStep",    32'(bus1.keyStep),    32'h0);
    chk("rst_swSync",     32'(bus1.swSync),     32'h0);
    chk("rst_keyStep_n",  32'(bus2.keyStep),    32'h0);
    rst_n = 1'b1;
    at_cyc(cyc + 4);

    // Clean press then early release.
    k = cyc;
    key_raw[0] = 1'b0;
    exp_ev(k + 6, 4'b0001, 4'b0000, 4'b0001);
    wait_cyc(k + 5);
    chk("s1_down_before", 32'(bus1.keyDown), 32'h0);
    wait_cyc(k + 6);
    chk("s1_down_after", 32'(bus1.keyDown), 32'h1);
    at_cyc(k + 8);
    key_raw[0] = 1'b1;
    exp_ev(k + 14, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(k + 14);
    chk("s1_down_release", 32'(bus1.keyDown), 32'h0);
    at_cyc(cyc + 4);

    // Bounce for 20 cycles, then hold with auto-repeat; release lands on a repeat slot.
    k = cyc;
    p = k + 26;
    exp_ev(p, 4'b0001, 4'b0000, 4'b0001);
    for (int m = 0; m < 9; m++) exp_ev(p + 10 + 3 * m, 4'b0000, 4'b0000, 4'b0001);
    exp_ev(p + 37, 4'b0000, 4'b0001, 4'b0000);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) at_cyc(k + 2 * j);
      key_raw[0] = (j % 2 == 0) ? 1'b0 : 1'b1;
    end
    at_cyc(k + 20);
    key_raw[0] = 1'b0;
    wait_cyc(k + 21);
    chk("s2_no_change_in_bounce", 32'(bus1.keyDown), 32'h0);
    wait_cyc(p);
    chk("s2_down_after", 32'(bus1.keyDown), 32'h1);
    at_cyc(p + 31);
    key_raw[0] = 1'b1;
    wait_cyc(p + 37);
    chk("s3_down_release", 32'(bus1.keyDown), 32'h0);
    at_cyc(cyc + 4);

    // Two keys pressed in the same cycle.
    k = cyc;
    key_raw = 4'b0110;
    exp_ev(k + 6, 4'b1001, 4'b0000, 4'b1001);
    wait_cyc(k + 6);
    chk("s4_down_pair", 32'(bus1.keyDown), 32'h9);
    at_cyc(k + 8);
    key_raw = 4'b1111;
    exp_ev(k + 14, 4'b0000, 4'b1001, 4'b0000);
    at_cyc(k + 16);

    // Reset while key 0 is repeating, key still held afterwards.
    k = cyc;
    p = k + 6;
    key_raw[0] = 1'b0;
    exp_ev(p, 4'b0001, 4'b0000, 4'b0001);
    exp_ev(p + 10, 4'b0000, 4'b0000, 4'b0001);
    at_cyc(p + 12);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_keyDown",  32'(bus1.keyDown),  32'h0);
    chk("s5_rst_keyStep",  32'(bus1.keyStep),  32'h0);
    chk("s5_rst_keyPress", 32'(bus1.keyPress), 32'h0);
    chk("s5_rst_keyDown_n", 32'(bus2.keyDown), 32'h0);
    at_cyc(p + 14);
    rst_n = 1'b1;
    rr = cyc;
    exp_ev(rr + 6, 4'b0001, 4'b0000, 4'b0001);
    wait_cyc(rr + 5);
    chk("s5_down_before", 32'(bus1.keyDown), 32'h0);
    wait_cyc(rr + 6);
    chk("s5_down_after", 32'(bus1.keyDown), 32'h1);
    at_cyc(rr + 8);
    key_raw[0] = 1'b1;
    exp_ev(rr + 14, 4'b0000, 4'b0001, 4'b0000);
    at_cyc(rr + 16);

    // Switch synchroniser latency.
    k = cyc;
    sw_raw = 10'h2A5;
    wait_cyc(k + 1);
    chk("s6_sw_edge1", 32'(bus1.swSync), 32'h0);
    wait_cyc(k + 2);
    chk("s6_sw_edge2", 32'(bus1.swSync), 32'h2A5);

    at_cyc(cyc + 20);
    chk("queue_rpt_drained",   32'(q1.size()), 32'h0);
    chk("queue_norpt_drained", 32'(q2.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
